// File: rtl/spimem_responder_pkg.sv
// spimem_responder_pkg: opcodes, FSM states and timing constants shared by the SPI flash responder.
package spimem_responder_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_WAKE = 8'hAB;
  localparam logic [7:0] OP_RST  = 8'hFF;
  localparam int SCK_RATIO = 8;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
endpackage

// File: rtl/spimem_responder_sync.sv
// spimem_responder_sync: input synchronizers plus SCK rise/fall and CSB falling-edge detection.
module spimem_responder_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic csb_in,
  input  logic sck_in,
  input  logic mosi_in,
  output logic csb,
  output logic mosi,
  output logic rise,
  output logic fall,
  output logic csb_fall
);
  logic [STAGES-1:0] csb_q, sck_q, mosi_q;
  logic sck_d, csb_d;
  always_ff @(posedge clk)
    if (!resetn) begin
      csb_q <= '1;
      sck_q <= '0;
      mosi_q <= '0;
      sck_d <= 1'b0;
      csb_d <= 1'b1;
    end else begin
      csb_q <= {csb_q[STAGES-2:0], csb_in};
      sck_q <= {sck_q[STAGES-2:0], sck_in};
      mosi_q <= {mosi_q[STAGES-2:0], mosi_in};
      sck_d <= sck_q[STAGES-1];
      csb_d <= csb_q[STAGES-1];
    end
  assign csb = csb_q[STAGES-1];
  assign mosi = mosi_q[STAGES-1];
  assign rise = sck_q[STAGES-1] & ~sck_d;
  assign fall = ~sck_q[STAGES-1] & sck_d;
  assign csb_fall = ~csb_q[STAGES-1] & csb_d;
endmodule

// File: rtl/spimem_responder.sv
// spimem_responder: SPI mode-0 flash read target serving bytes from a 32-bit word memory bus.
// Define SPIMEM_RESPONDER_FASTREAD_EN to accept fast-read 0x0B with FAST_DUMMY dummy clocks.
module spimem_responder
  import spimem_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FAST_DUMMY = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_csb,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [23:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        underrun,
  output logic        cmd_err
);
  state_t state, nxt;
  logic csb_s, mosi_s, rise, fall, csb_fall;
  logic [4:0] cnt;
  logic [22:0] sr;
  logic [23:0] addr_in, byte_addr, q_addr, fetch_addr;
  logic [7:0] op_in, sh, lane_byte, byte_v;
  logic [31:0] cur_word, nxt_word, word;
  logic fast, is_fast, fetch, err_n, q_valid, stale, take, cur_valid, nxt_valid, avail, data_fall, last_bit;

  spimem_responder_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .resetn(resetn), .csb_in(spi_csb), .sck_in(spi_clk), .mosi_in(spi_mosi),
    .csb(csb_s), .mosi(mosi_s), .rise(rise), .fall(fall), .csb_fall(csb_fall)
  );

`ifdef SPIMEM_RESPONDER_FASTREAD_EN
  assign is_fast = op_in == OP_FAST;
`else
  assign is_fast = 1'b0;
`endif

  assign addr_in = {sr, mosi_s};
  assign op_in = addr_in[7:0];
  assign avail = cur_valid | nxt_valid;
  assign word = cur_valid ? cur_word : nxt_word;
  assign lane_byte = word[{byte_addr[1:0], 3'b000} +: 8];
  assign byte_v = avail ? lane_byte : 8'hFF;
  assign last_bit = cnt == 5'd7;
  assign data_fall = state == DATA && fall && !csb_s;
  assign busy = ~csb_s;
  assign spi_miso_oe = state == DATA && !csb_s;
  // a response that lands after CSB rose belongs to a finished transaction
  assign take = mem_valid && mem_ready && !stale && !csb_s;

  always_comb begin
    nxt = state;
    fetch = 1'b0;
    fetch_addr = '0;
    err_n = 1'b0;
    if (csb_s) nxt = IDLE;
    else case (state)
      IDLE: nxt = csb_fall ? CMD : IDLE;
      CMD: if (rise && last_bit) begin
        nxt = (op_in == OP_READ || is_fast) ? ADDR : IGNORE;
        err_n = !(op_in == OP_READ || is_fast || op_in == OP_WAKE || op_in == OP_RST);
      end
      ADDR: if (rise && cnt == 5'd23) begin
        nxt = fast ? DUMMY : DATA;
        fetch = 1'b1;
        fetch_addr = {addr_in[23:2], 2'b00};
      end
      DUMMY: if (rise && cnt == 5'(FAST_DUMMY - 1)) nxt = DATA;
      DATA: if (fall && last_bit && byte_addr[1:0] == 2'd3) begin
        fetch = 1'b1;
        fetch_addr = {byte_addr[23:2] + 22'd1, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      fast <= 1'b0;
      byte_addr <= '0;
      sh <= '0;
      spi_miso <= 1'b0;
      underrun <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state <= nxt;
      cmd_err <= err_n;
      if (rise) sr <= addr_in[22:0];
      if (state == CMD && rise && last_bit) fast <= is_fast;
      if (csb_s || state == IDLE) cnt <= '0;
      else if (state == DATA) begin
        if (fall) cnt <= last_bit ? '0 : cnt + 5'd1;
      end else if (rise) cnt <= (nxt != state) ? '0 : cnt + 5'd1;
      if (state == ADDR && fetch) byte_addr <= addr_in;
      else if (data_fall && last_bit) byte_addr <= byte_addr + 24'd1;
      if (csb_s) spi_miso <= 1'b0;
      else if (data_fall) begin
        spi_miso <= cnt == 5'd0 ? byte_v[7] : sh[7];
        sh <= cnt == 5'd0 ? {byte_v[6:0], 1'b0} : {sh[6:0], 1'b0};
        if (cnt == 5'd0 && !avail) underrun <= 1'b1;
      end
    end

  // one request in flight; a fetch raised while busy waits in a single-entry queue
  always_ff @(posedge clk)
    if (!resetn) begin
      mem_valid <= 1'b0;
      mem_addr <= '0;
      q_valid <= 1'b0;
      q_addr <= '0;
      stale <= 1'b0;
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      cur_word <= '0;
      nxt_word <= '0;
    end else begin
      if (mem_valid) begin
        if (mem_ready) mem_valid <= 1'b0;
      end else if (q_valid && !csb_s) begin
        mem_valid <= 1'b1;
        mem_addr <= q_addr;
      end else if (fetch) begin
        mem_valid <= 1'b1;
        mem_addr <= fetch_addr;
      end
      if (csb_s) q_valid <= 1'b0;
      else if (fetch && (mem_valid || q_valid)) begin
        q_valid <= 1'b1;
        q_addr <= fetch_addr;
      end else if (!mem_valid && q_valid) q_valid <= 1'b0;
      stale <= mem_valid && !mem_ready && (stale || csb_s);
      if (csb_s) begin
        cur_valid <= 1'b0;
        nxt_valid <= 1'b0;
      end else begin
        if (take) begin
          nxt_word <= mem_rdata;
          nxt_valid <= 1'b1;
        end else if (nxt_valid && !cur_valid) begin
          cur_word <= nxt_word;
          cur_valid <= 1'b1;
          nxt_valid <= 1'b0;
        end
        if (data_fall && last_bit && byte_addr[1:0] == 2'd3) cur_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spimem_responder.sv
// tb_spimem_responder: SPI host plus word-memory model with a scoreboard of expected bytes and fetch addresses.
module tb_spimem_responder;
  logic clk = 1'b0, resetn = 1'b0, spi_csb = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, mem_valid, busy, underrun, cmd_err;
  logic mem_ready = 1'b0;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  int total = 0, bad = 0;
  int lat = 0, cur_lat = 0, wcnt = 0;
  int err_cnt = 0, oe_cnt = 0, mv_cnt = 0;
  logic [7:0] exp_q[$];
  logic [23:0] fetch_q[$];

  typedef struct {
    logic [7:0] op;
    logic [23:0] addr;
    int n;
    int lat;
    logic [31:0] exp;
    logic urun;
  } vec_t;
  typedef struct {
    logic [7:0] op;
    int err;
  } ign_t;

  vec_t vecs[5];
  ign_t ign[4];
  int n_vec, n_ign;

  spimem_responder dut (
    .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .underrun(underrun), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000100: return 32'h44332211;
      24'hFFFFFC: return 32'hDDCCBBAA;
      24'h000000: return 32'h04030201;
      24'h000004: return 32'h08070605;
      default:    return 32'hA5A5A5A5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory: answers after the latency in force when the request appeared
  initial forever begin
    @(negedge clk);
    if (mem_ready) mem_ready = 1'b0;
    else if (mem_valid) begin
      if (wcnt == 0) cur_lat = lat;
      if (wcnt >= cur_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wcnt = 0;
        if (fetch_q.size() > 0) chk("fetch_addr", mem_addr, fetch_q.pop_front());
        else begin
          total++;
          bad++;
          $display("FAIL unexpected_fetch: got %0h expected none", mem_addr);
        end
      end else wcnt++;
    end else wcnt = 0;
  end

  initial forever begin
    @(negedge clk);
    if (cmd_err) err_cnt++;
    if (spi_miso_oe) oe_cnt++;
    if (mem_valid) mv_cnt++;
  end

  task automatic csb_lo();
    spi_csb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csb_hi();
    spi_csb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // SCK period is 8 clk; MISO is sampled just before each rising edge
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rx;
    logic [23:0] a;
    lat = v.lat;
    fetch_q.push_back({v.addr[23:2], 2'b00});
    for (int i = 0; i < v.n; i++) begin
      a = v.addr + 24'(i);
      exp_q.push_back(v.exp[31 - 8 * i -: 8]);
      if (a[1:0] == 2'd3) begin
        a = a + 24'd1;
        fetch_q.push_back({a[23:2], 2'b00});
      end
    end
    csb_lo();
    spi_byte(v.op, 8, rx);
    spi_byte(v.addr[23:16], 8, rx);
    spi_byte(v.addr[15:8], 8, rx);
    spi_byte(v.addr[7:0], 8, rx);
    if (v.op == 8'h0B) spi_byte(8'h00, 8, rx);
    for (int i = 0; i < v.n; i++) begin
      spi_byte(8'h00, 8, rx);
      chk("data_byte", rx, exp_q.pop_front());
    end
    chk("oe_in_data", spi_miso_oe, 1);
    csb_hi();
    chk("oe_after_csb", spi_miso_oe, 0);
    chk("busy_idle", busy, 0);
    chk("fetches_done", fetch_q.size(), 0);
    chk("underrun", underrun, v.urun);
  endtask

  initial begin
    logic [7:0] rx;
    vecs[0] = '{8'h03, 24'h000101, 3, 0, 32'h22334400, 1'b0};
    vecs[1] = '{8'h03, 24'hFFFFFE, 4, 0, 32'hCCDD0102, 1'b0};
    vecs[2] = '{8'h03, 24'h000000, 4, 0, 32'h01020304, 1'b0};
    n_vec = 3;
`ifdef SPIMEM_RESPONDER_FASTREAD_EN
    vecs[n_vec] = '{8'h0B, 24'h000100, 2, 40, 32'h11220000, 1'b0};
    n_vec++;
`endif
    vecs[n_vec] = '{8'h03, 24'h000100, 2, 40, 32'hFF220000, 1'b1};
    n_vec++;
    ign[0] = '{8'h5A, 1};
    ign[1] = '{8'hFF, 0};
    ign[2] = '{8'hAB, 0};
    n_ign = 3;
`ifndef SPIMEM_RESPONDER_FASTREAD_EN
    ign[n_ign] = '{8'h0B, 1};
    n_ign++;
`endif

    repeat (5) @(negedge clk);
    chk("reset_outputs", {spi_miso, spi_miso_oe, mem_valid, busy, underrun, cmd_err, mem_addr}, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int k = 0; k < n_ign; k++) begin
      err_cnt = 0;
      oe_cnt = 0;
      mv_cnt = 0;
      csb_lo();
      spi_byte(ign[k].op, 8, rx);
      repeat (3) spi_byte(8'h00, 8, rx);
      csb_hi();
      chk("ignore_cmd_err_cycles", err_cnt, ign[k].err);
      chk("ignore_oe_cycles", oe_cnt, 0);
      chk("ignore_fetch_cycles", mv_cnt, 0);
    end
    run_vec(vecs[0]);

    oe_cnt = 0;
    mv_cnt = 0;
    csb_lo();
    spi_byte(8'h03, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h01, 4, rx);
    csb_hi();
    chk("abort12_busy", busy, 0);
    chk("abort12_oe_cycles", oe_cnt, 0);
    chk("abort12_fetch_cycles", mv_cnt, 0);

    lat = 200;
    fetch_q.push_back(24'h000100);
    csb_lo();
    spi_byte(8'h03, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h01, 8, rx);
    spi_byte(8'h00, 8, rx);
    csb_hi();
    chk("abort_req_held", mem_valid, 1);
    chk("abort_busy", busy, 0);
    run_vec('{8'h03, 24'h000000, 2, 0, 32'h01020000, 1'b0});

    for (int k = 0; k < n_vec; k++) run_vec(vecs[k]);

    lat = 0;
    fetch_q.push_back(24'h000000);
    csb_lo();
    spi_byte(8'h03, 8, rx);
    repeat (3) spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 8, rx);
    chk("pre_reset_byte", rx, 8'h01);
    chk("pre_reset_oe", spi_miso_oe, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_in_data", {spi_miso, spi_miso_oe, mem_valid, busy, underrun, cmd_err, mem_addr}, 0);
    spi_csb = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("after_reset_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
